// File: rtl/edge_sequencer.sv
// edge_sequencer: accepts wireframe edges into a small FIFO, and for each
// edge it loads the point writer with min/max ordered endpoints. Each
// generated point is then relayed to the framebuffer under an ack handshake.
// An end-of-frame marker in the stream produces a one-cycle frame_done pulse.
//
// Ports
//   clock, reset             : rising-edge clock, synchronous active-high reset
//   edge_valid/edge_ready    : upstream push handshake
//   edge_x0/x1, edge_y0/y1   : raw endpoints
//   edge_type                : 01 vertical, 10 horizontal, 11 marker, 00 null
//   pw_xstart..pw_yend       : ordered endpoints to the point writer
//   pw_etype, pw_reset       : point writer type/enable and counter clear
//   pw_done_point            : point consumed strobe
//   pw_pvalid, pw_donedge    : point writer status
//   pw_xval, pw_yval         : current point from the point writer
//   fb_we, fb_x, fb_y, fb_ack: framebuffer write port
//   frame_done, busy         : status
//   point_count              : points written since the last frame_done
module edge_sequencer #(
  parameter int FIFO_AW = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             edge_valid,
  output logic             edge_ready,
  input  logic [6:0]       edge_x0,
  input  logic [6:0]       edge_x1,
  input  logic [5:0]       edge_y0,
  input  logic [5:0]       edge_y1,
  input  logic [1:0]       edge_type,
  output logic [6:0]       pw_xstart,
  output logic [6:0]       pw_xend,
  output logic [5:0]       pw_ystart,
  output logic [5:0]       pw_yend,
  output logic [2:0]       pw_etype,
  output logic             pw_reset,
  output logic             pw_done_point,
  input  logic             pw_pvalid,
  input  logic             pw_donedge,
  input  logic [7:0]       pw_xval,
  input  logic [5:0]       pw_yval,
  output logic             fb_we,
  output logic [7:0]       fb_x,
  output logic [5:0]       fb_y,
  input  logic             fb_ack,
  output logic             frame_done,
  output logic             busy,
  output logic [CNT_W-1:0] point_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int ENT_W = 28;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_SETTLE,
    S_FRAME
  } state_t;

  state_t               state_q, state_d;
  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     cnt_q, cnt_d;
  logic [6:0]           xstart_q, xstart_d, xend_q, xend_d;
  logic [5:0]           ystart_q, ystart_d, yend_q, yend_d;
  logic [1:0]           type_q, type_d;
  logic [CNT_W-1:0]     point_count_q, point_count_d;

  logic                 full, empty, push, pop;
  logic [ENT_W-1:0]     head;
  logic [1:0]           head_type;
  logic [6:0]           head_x0, head_x1;
  logic [5:0]           head_y0, head_y1;
  logic                 loaded;

  function automatic logic [6:0] min7(input logic [6:0] a, input logic [6:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [6:0] max7(input logic [6:0] a, input logic [6:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [5:0] min6(input logic [5:0] a, input logic [5:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [5:0] max6(input logic [5:0] a, input logic [5:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign full       = (cnt_q == DEPTH[FIFO_AW:0]);
  assign empty      = (cnt_q == '0);
  assign edge_ready = ~full;
  assign push       = edge_valid & ~full;
  assign pop        = (state_q == S_IDLE) & ~empty;

  assign head      = mem_q[rd_ptr_q];
  assign head_type = head[27:26];
  assign head_x0   = head[25:19];
  assign head_x1   = head[18:12];
  assign head_y0   = head[11:6];
  assign head_y1   = head[5:0];

  // Outputs are gated by reset so the reset cycle itself already presents
  // the idle view to the point writer and the framebuffer.
  assign loaded        = (state_q == S_LOAD) | (state_q == S_RUN);
  assign pw_etype      = (loaded & ~reset) ? {1'b0, type_q} : 3'b100;
  assign pw_reset      = reset | (state_q == S_LOAD);
  assign fb_we         = ~reset & (state_q == S_RUN) & pw_pvalid;
  assign fb_x          = pw_xval;
  assign fb_y          = pw_yval;
  assign pw_done_point = fb_we & fb_ack;
  assign frame_done    = ~reset & (state_q == S_FRAME);
  assign busy          = (state_q != S_IDLE) | ~empty;
  assign point_count   = point_count_q;
  assign pw_xstart     = xstart_q;
  assign pw_xend       = xend_q;
  assign pw_ystart     = ystart_q;
  assign pw_yend       = yend_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    xstart_d      = xstart_q;
    xend_d        = xend_q;
    ystart_d      = ystart_q;
    yend_d        = yend_q;
    type_d        = type_q;
    point_count_d = point_count_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          case (head_type)
            2'b00: state_d = S_IDLE;
            2'b11: state_d = S_FRAME;
            default: begin
              xstart_d = min7(head_x0, head_x1);
              xend_d   = max7(head_x0, head_x1);
              ystart_d = min6(head_y0, head_y1);
              yend_d   = max6(head_y0, head_y1);
              type_d   = head_type;
              state_d  = S_LOAD;
            end
          endcase
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (fb_we && fb_ack) point_count_d = sat_inc(point_count_q);
        // Leave only when no write is left waiting for its ack.
        if (pw_donedge && (!fb_we || fb_ack)) state_d = S_SETTLE;
      end
      S_SETTLE: state_d = S_IDLE;
      S_FRAME: begin
        point_count_d = '0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      xstart_q      <= '0;
      xend_q        <= '0;
      ystart_q      <= '0;
      yend_q        <= '0;
      type_q        <= '0;
      point_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      xstart_q      <= xstart_d;
      xend_q        <= xend_d;
      ystart_q      <= ystart_d;
      yend_q        <= yend_d;
      type_q        <= type_d;
      point_count_q <= point_count_d;
    end
  end

  // FIFO storage needs no reset: emptiness is carried by cnt_q.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {edge_type, edge_x0, edge_x1, edge_y0, edge_y1};
  end

endmodule

// File: tb/tb_edge_sequencer.sv
module tb_edge_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        edge_valid;
  logic        edge_ready;
  logic [6:0]  edge_x0, edge_x1;
  logic [5:0]  edge_y0, edge_y1;
  logic [1:0]  edge_type;
  logic [6:0]  pw_xstart, pw_xend;
  logic [5:0]  pw_ystart, pw_yend;
  logic [2:0]  pw_etype;
  logic        pw_reset, pw_done_point;
  logic        pw_pvalid, pw_donedge;
  logic [7:0]  pw_xval;
  logic [5:0]  pw_yval;
  logic        fb_we;
  logic [7:0]  fb_x;
  logic [5:0]  fb_y;
  logic        fb_ack = 1'b1;
  logic        frame_done, busy;
  logic [15:0] point_count;

  edge_sequencer #(.FIFO_AW(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_x0(edge_x0), .edge_x1(edge_x1), .edge_y0(edge_y0), .edge_y1(edge_y1),
    .edge_type(edge_type),
    .pw_xstart(pw_xstart), .pw_xend(pw_xend), .pw_ystart(pw_ystart), .pw_yend(pw_yend),
    .pw_etype(pw_etype), .pw_reset(pw_reset), .pw_done_point(pw_done_point),
    .pw_pvalid(pw_pvalid), .pw_donedge(pw_donedge), .pw_xval(pw_xval), .pw_yval(pw_yval),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_ack(fb_ack),
    .frame_done(frame_done), .busy(busy), .point_count(point_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       mark;
    logic [7:0] x;
    logic [5:0] y;
  } tok_t;

  tok_t expq[$];
  int   logx[$];
  int   logy[$];
  int   mcount = 0;
  int   frames_seen = 0;
  int   markers_pushed = 0;
  bit   prev_pend = 0;
  bit   prev_fd = 0;
  int   prev_x = 0, prev_y = 0;
  int   ack_mode = 0;
  int   cyc = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Framebuffer acknowledge pattern.
  always @(posedge clock) begin
    #1;
    cyc++;
    case (ack_mode)
      0:       fb_ack = 1'b1;
      1:       fb_ack = (cyc % 3 == 0);
      2:       fb_ack = 1'($urandom_range(0, 1));
      default: fb_ack = 1'b0;
    endcase
  end

  // Point writer stand-in: walks from start to end along the edge's axis,
  // advancing on each consumed point; one priming cycle after its clear.
  logic       pw_act = 1'b0;
  logic       pw_dn = 1'b0;
  logic [6:0] pw_cur = '0;
  int         pw_gap = 0;
  logic       horiz;
  logic [6:0] pw_end;

  assign horiz      = (pw_etype[1:0] == 2'b10);
  assign pw_end     = horiz ? pw_xend : {1'b0, pw_yend};
  assign pw_pvalid  = pw_act && !pw_dn && (pw_gap == 0);
  assign pw_donedge = pw_act && pw_dn;
  assign pw_xval    = horiz ? {pw_cur, 1'b0} : {pw_xstart, 1'b0};
  assign pw_yval    = horiz ? pw_ystart : pw_cur[5:0];

  always @(posedge clock) begin
    if (pw_reset) begin
      pw_act <= (pw_etype != 3'b100);
      pw_dn  <= 1'b0;
      pw_cur <= horiz ? pw_xstart : {1'b0, pw_ystart};
      pw_gap <= 1;
    end else if (pw_etype == 3'b100) begin
      pw_act <= 1'b0;
      pw_dn  <= 1'b0;
    end else if (pw_act && !pw_dn) begin
      if (pw_done_point) begin
        if (pw_cur == pw_end) pw_dn <= 1'b1;
        else pw_cur <= pw_cur + 1'b1;
        pw_gap <= (ack_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      end else if (pw_gap > 0) begin
        pw_gap <= pw_gap - 1;
      end
    end
  end

  // Reference: the ordered list of points (and frame markers) each pushed
  // edge must produce.
  task automatic add_edge(input int x0, input int x1, input int y0, input int y1, input int t);
    tok_t tk;
    int lo, hi, fixed;
    if (t == 2) begin
      lo = (x0 < x1) ? x0 : x1;
      hi = (x0 < x1) ? x1 : x0;
      fixed = (y0 < y1) ? y0 : y1;
      for (int v = lo; v <= hi; v++) begin
        tk.mark = 1'b0; tk.x = 8'(2 * v); tk.y = 6'(fixed);
        expq.push_back(tk);
      end
    end else if (t == 1) begin
      lo = (y0 < y1) ? y0 : y1;
      hi = (y0 < y1) ? y1 : y0;
      fixed = (x0 < x1) ? x0 : x1;
      for (int v = lo; v <= hi; v++) begin
        tk.mark = 1'b0; tk.x = 8'(2 * fixed); tk.y = 6'(v);
        expq.push_back(tk);
      end
    end else if (t == 3) begin
      tk.mark = 1'b1; tk.x = '0; tk.y = '0;
      expq.push_back(tk);
      markers_pushed++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input int x0, input int x1, input int y0, input int y1, input int t);
    bit ok;
    int n;
    n = 0;
    edge_valid = 1'b1;
    edge_x0 = 7'(x0); edge_x1 = 7'(x1);
    edge_y0 = 6'(y0); edge_y1 = 6'(y1);
    edge_type = 2'(t);
    do begin
      ok = edge_ready;
      @(posedge clock); #1;
      n++;
    end while (!ok && n < 3000);
    edge_valid = 1'b0;
    if (ok) add_edge(x0, x1, y0, y1, t);
    else chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  function automatic int lx(input int i);
    return (i < logx.size()) ? logx[i] : -1;
  endfunction

  function automatic int ly(input int i);
    return (i < logy.size()) ? logy[i] : -1;
  endfunction

  // Per-cycle comparison against the reference.
  always @(negedge clock) begin
    if (reset) begin
      expq.delete();
      mcount    = 0;
      prev_pend = 0;
      prev_fd   = 0;
    end else begin
      chk("point_count", int'(point_count), mcount);
      chk("done_point", pw_done_point, fb_we & fb_ack);
      if (fb_we) chk("we_outside_run", pw_etype[2], 0);
      if (!busy) chk("idle_etype", pw_etype, 4);
      if (prev_pend) begin
        chk("we_hold", fb_we, 1);
        chk("x_hold", fb_x, prev_x);
        chk("y_hold", fb_y, prev_y);
      end
      if (fb_we && fb_ack) begin
        if (expq.size() == 0 || expq[0].mark) begin
          chk("unexpected_write", 1, 0);
        end else begin
          chk("wr_x", fb_x, expq[0].x);
          chk("wr_y", fb_y, expq[0].y);
          void'(expq.pop_front());
        end
        logx.push_back(fb_x);
        logy.push_back(fb_y);
        mcount++;
      end
      if (frame_done) begin
        chk("fd_single", prev_fd, 0);
        if (expq.size() == 0 || !expq[0].mark) chk("unexpected_frame", 1, 0);
        else void'(expq.pop_front());
        frames_seen++;
        mcount = 0;
      end
      prev_fd   = frame_done;
      prev_pend = fb_we && !fb_ack;
      prev_x    = fb_x;
      prev_y    = fb_y;
    end
  end

  initial begin
    int f0, n, t, sum;
    reset = 1'b1;
    edge_valid = 1'b0;
    edge_x0 = '0; edge_x1 = '0; edge_y0 = '0; edge_y1 = '0; edge_type = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pw_reset", pw_reset, 1);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_etype", pw_etype, 4);
    chk("rst_busy", busy, 0);
    chk("rst_ready", edge_ready, 1);
    chk("rst_count", point_count, 0);
    chk("rst_xstart", pw_xstart, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("pw_reset_low", pw_reset, 0);

    // Horizontal edge, ack tied high.
    logx.delete(); logy.delete();
    push(5, 8, 10, 10, 2);
    wait_idle(200);
    chk("h_n", logx.size(), 4);
    chk("h_x0", lx(0), 10); chk("h_y0", ly(0), 10);
    chk("h_x1", lx(1), 12); chk("h_x2", lx(2), 14);
    chk("h_x3", lx(3), 16); chk("h_y3", ly(3), 10);
    chk("h_count", point_count, 4);

    // Reversed vertical edge, ack every third cycle.
    ack_mode = 1;
    logx.delete(); logy.delete();
    push(3, 3, 7, 4, 1);
    wait_idle(300);
    chk("v_n", logx.size(), 4);
    chk("v_x0", lx(0), 6); chk("v_y0", ly(0), 4);
    chk("v_y1", ly(1), 5); chk("v_y2", ly(2), 6);
    chk("v_x3", lx(3), 6); chk("v_y3", ly(3), 7);

    // Fill the FIFO behind a stalled edge.
    ack_mode = 3;
    @(posedge clock); #1;
    logx.delete(); logy.delete();
    push(0, 2, 1, 1, 2);
    repeat (4) @(posedge clock);
    #1;
    chk("stall_we", fb_we, 1);
    push(10, 11, 3, 3, 2);
    push(20, 20, 5, 6, 1);
    push(31, 30, 9, 9, 2);
    push(40, 40, 12, 11, 1);
    chk("full_ready", edge_ready, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("full_hold", edge_ready, 0);
    ack_mode = 0;
    push(50, 51, 2, 2, 2);
    wait_idle(300);
    chk("fill_n", logx.size(), 13);
    chk("fill_last_x", lx(12), 102);

    // Null, short horizontal, then frame marker.
    logx.delete(); logy.delete();
    f0 = frames_seen;
    push(9, 9, 9, 9, 0);
    push(0, 1, 0, 0, 2);
    push(0, 0, 0, 0, 3);
    wait_idle(200);
    chk("nf_n", logx.size(), 2);
    chk("nf_x0", lx(0), 0); chk("nf_y0", ly(0), 0);
    chk("nf_x1", lx(1), 2); chk("nf_y1", ly(1), 0);
    chk("nf_frames", frames_seen - f0, 1);
    chk("nf_count", point_count, 0);

    // Reset in the middle of an edge.
    logx.delete(); logy.delete();
    push(0, 5, 20, 20, 2);
    n = 0;
    while (logx.size() < 2 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("mid_two_points", logx.size(), 2);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mid_fb_we", fb_we, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", edge_ready, 1);
    chk("mid_etype", pw_etype, 4);
    chk("mid_count", point_count, 0);
    logx.delete(); logy.delete();
    push(4, 4, 9, 9, 1);
    wait_idle(100);
    chk("post_n", logx.size(), 1);
    chk("post_x", lx(0), 8); chk("post_y", ly(0), 9);

    // Degenerate edge at the far x limit.
    logx.delete(); logy.delete();
    push(127, 127, 33, 33, 2);
    wait_idle(100);
    chk("deg_n", logx.size(), 1);
    chk("deg_x", lx(0), 254); chk("deg_y", ly(0), 33);

    // Randomized edge stream with random ack and point gaps.
    ack_mode = 2;
    sum = 0;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 9);
      t = (n == 0) ? 0 : (n == 1) ? 3 : (n < 6) ? 1 : 2;
      push($urandom_range(0, 127), $urandom_range(0, 127),
           $urandom_range(0, 63), $urandom_range(0, 63), t);
      if (($urandom_range(0, 3) == 0)) begin
        repeat ($urandom_range(1, 5)) @(posedge clock);
        #1;
      end
      sum++;
    end
    wait_idle(40000);
    chk("rand_pushed", sum, 40);
    chk("exp_empty", expq.size(), 0);
    chk("frames_all", frames_seen, markers_pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_sequencer.md
Name: edge_sequencer

Overview:
Sequences wireframe edges through the point-writer datapath, one edge at a time. Upstream pushes edges into a small FIFO. For each edge the block normalises the endpoints, loads the point writer and relays each generated point to the framebuffer write port under an ack handshake. End-of-frame markers in the edge stream produce a frame_done pulse.

Parameters:
FIFO_AW, 2, log2 of edge FIFO depth (depth = 2**FIFO_AW = 4)
CNT_W, 16, width of the per-frame point counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
edge_valid  input  1  upstream edge present
edge_ready  output  1  FIFO can accept; push = edge_valid & edge_ready
edge_x0  input  7  first x endpoint
edge_x1  input  7  second x endpoint
edge_y0  input  6  first y endpoint
edge_y1  input  6  second y endpoint
edge_type  input  2  01 vertical, 10 horizontal, 11 end-of-frame marker, 00 null
pw_xstart  output  7  to point writer, min(x0,x1)
pw_xend  output  7  max(x0,x1)
pw_ystart  output  6  min(y0,y1)
pw_yend  output  6  max(y0,y1)
pw_etype  output  3  {0,type} while loaded, 3'b100 when idle
pw_reset  output  1  one-cycle counter clear to point writer
pw_done_point  output  1  point consumed strobe to point writer
pw_pvalid  input  1  point writer has a point
pw_donedge  input  1  point writer finished the edge
pw_xval  input  8  point x (already doubled)
pw_yval  input  6  point y
fb_we  output  1  framebuffer write request
fb_x  output  8  write x
fb_y  output  6  write y
fb_ack  input  1  framebuffer accepted write
frame_done  output  1  one-cycle pulse per end-of-frame marker
busy  output  1  state != IDLE or FIFO non-empty
point_count  output  CNT_W  points written since last frame_done

Behaviour:
- Reset (any cycle, including mid-edge):
  - state=IDLE and FIFO emptied.
  - pw_etype=3'b100, pw_reset=1 for the reset cycle, then 0.
  - fb_we=0, pw_done_point=0, frame_done=0, point_count=0.
  - All pw_x*/pw_y* registers = 0.
- FIFO:
  - edge_ready = ~full.
  - Push and pop in the same cycle are legal when not full; occupancy is unchanged.
  - When full, only pop occurs.
  - Pop happens only in IDLE when non-empty.
- FSM states: IDLE, LOAD, RUN, SETTLE, FRAME.
- IDLE:
  - pw_etype=3'b100, which holds the point writer cleared.
  - If the FIFO is non-empty, pop the head entry and decode its type:
    - type 00: discard and stay in IDLE. Cost is one cycle per null entry.
    - type 11: go to FRAME.
    - type 01/10: register the min/max-swapped endpoints and type, then go to LOAD.
- LOAD (1 cycle): pw_etype={1'b0,type}, pw_reset=1. Go to RUN.
- RUN:
  - pw_etype held.
  - fb_we = pw_pvalid. fb_x/fb_y are passed through from pw_xval/pw_yval.
  - pw_done_point = fb_we & fb_ack, combinational.
  - fb_we and fb_x/fb_y stay stable until fb_ack.
  - point_count increments on each fb_we & fb_ack. It saturates at all-ones.
  - If pw_donedge=1 and no handshake is in progress (fb_we=0, or fb_ack=1 this cycle), go to SETTLE.
  - If pw_donedge and an unacked fb_we coincide, remain in RUN until ack.
- SETTLE (1 cycle): pw_etype=3'b100, fb_we=0. Go to IDLE. The next pop can occur on the following cycle.
- FRAME (1 cycle):
  - frame_done=1.
  - point_count clears to 0 on the next edge.
  - Go to IDLE.
- Degenerate edges:
  - x0==x1 on a horizontal edge, or y0==y1 on a vertical edge, writes exactly one point.
  - Reversed endpoints are swapped, so the written set is identical.
- Latency:
  - Pop to LOAD: 1 cycle.
  - First fb_we no earlier than 2 cycles after LOAD.
  - Minimum 4 cycles of overhead per edge, beyond 1 cycle per point with fb_ack tied high.
- No fb_we is issued outside RUN.

Test Plan:
- Horizontal edge (x0=5,x1=8,y=10), fb_ack tied 1 -> four writes (10,10),(12,10),(14,10),(16,10); point_count=4; return to IDLE.
- Reversed vertical edge (x=3, y0=7, y1=4) with fb_ack asserted every third cycle -> writes (6,4),(6,5),(6,6),(6,7), in order and held stable between acks.
- Four edges pushed back-to-back, then a fifth -> edge_ready=0 while full; all five edges drawn in order, none lost.
- Sequence null, horizontal (x 0..1, y 0), marker -> null dropped, two writes, then frame_done one-cycle pulse; point_count reads 0 after FRAME.
- reset asserted during RUN after 2 of 6 points -> next cycle fb_we=0, busy=0, FIFO empty, pw_etype=3'b100; a subsequent push is accepted normally.
- Degenerate edge x0=x1=127 horizontal -> exactly one write (254,y); no hang on the point writer's counter-wrap donedge.
